// File: rtl/ad4630_acq_ctrl_pkg.sv
// Shared types and helpers for the AD4630 acquisition sequencer: state encoding,
// sample/lane geometry and the lane de-interleave function.
package ad4630_acq_ctrl_pkg;

  localparam int AD4630_SAMPLE_W = 24;
  localparam int AD4630_LANES    = 4;
  localparam int AD4630_LANE_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT_XFER = 3'd1,
    ST_INIT_REL  = 3'd2,
    ST_CNV_HI    = 3'd3,
    ST_CONV_WAIT = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_REL  = 3'd6
  } state_t;

  // Lane k carries sample bits 23-k, 19-k, ... MSB first, so the lanes interleave nibble-wise.
  function automatic logic signed [AD4630_SAMPLE_W-1:0] deinterleave(
    input logic [AD4630_SAMPLE_W-1:0] lanes
  );
    logic signed [AD4630_SAMPLE_W-1:0] s;
    s = '0;
    for (int j = 0; j < AD4630_LANE_W; j++) begin
      for (int k = 0; k < AD4630_LANES; k++) begin
        s[AD4630_SAMPLE_W-1-AD4630_LANES*j-k] = lanes[AD4630_LANE_W*k+AD4630_LANE_W-1-j];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/ad4630_period_tick.sv
// Sample-period counter for the AD4630 sequencer; counts only while run is high
// and is held at zero otherwise, so the first tick lands a full period after run rises.
module ad4630_period_tick #(
  parameter int SAMPLE_PERIOD = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/ad4630_acq_ctrl.sv
// AD4630 acquisition sequencer: config-word init through the SPI engine, CNV pacing,
// read issue and 4-lane sample reassembly. Optional macro AD4630_OFFSET_CAL_EN adds offset removal.
module ad4630_acq_ctrl
  import ad4630_acq_ctrl_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 500,
  parameter int CNV_HIGH_CYC  = 4,
  parameter int CONV_WAIT_CYC = 30,
  parameter int INIT_WORDS    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_init_req,
  output logic [2:0]  o_init_idx,
  input  logic [23:0] i_init_word,
  output logic        o_spi_start,
  input  logic        i_spi_done,
  output logic        o_adc_init,
  output logic [23:0] o_adc_init_data,
  input  logic [23:0] i_lane_data,
  input  logic [23:0] i_offset,
  output logic        o_cnv,
  output logic [23:0] o_sample,
  output logic        o_sample_valid,
  output logic        o_init_done,
  output logic        o_overrun,
  output logic [2:0]  o_state
);

  localparam logic [2:0] LAST_IDX = 3'(INIT_WORDS - 1);

  state_t      state, state_nxt;
  logic [15:0] cyc;
  logic [2:0]  idx;
  logic        last_word;
  logic        init_pend;
  logic        init_done;
  logic        overrun;
  logic        tick;
  logic        start_init, enter_xfer, xfer_done, init_finish, capture, tick_drop;

  ad4630_period_tick #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk  (i_clk),
    .rst_n(i_rst),
    .run  (i_en && init_done),
    .tick (tick)
  );

  always_comb begin
    state_nxt   = state;
    start_init  = 1'b0;
    enter_xfer  = 1'b0;
    xfer_done   = 1'b0;
    init_finish = 1'b0;
    capture     = 1'b0;
    // A request arriving this cycle already outranks the tick.
    tick_drop   = tick && (state != ST_IDLE || init_pend || i_init_req);
    case (state)
      ST_IDLE: begin
        if (init_pend) begin
          start_init = 1'b1;
          enter_xfer = 1'b1;
          state_nxt  = ST_INIT_XFER;
        end else if (tick && !i_init_req) begin
          state_nxt = ST_CNV_HI;
        end
      end
      ST_INIT_XFER: begin
        if (i_spi_done) begin
          xfer_done = 1'b1;
          state_nxt = ST_INIT_REL;
        end
      end
      ST_INIT_REL: begin
        if (!i_spi_done) begin
          if (last_word) begin
            init_finish = 1'b1;
            state_nxt   = ST_IDLE;
          end else begin
            enter_xfer = 1'b1;
            state_nxt  = ST_INIT_XFER;
          end
        end
      end
      ST_CNV_HI: begin
        if (cyc == 16'(CNV_HIGH_CYC - 1)) state_nxt = ST_CONV_WAIT;
      end
      ST_CONV_WAIT: begin
        if (cyc == 16'(CONV_WAIT_CYC - 1)) state_nxt = ST_READ;
      end
      ST_READ: begin
        if (i_spi_done) begin
          capture   = 1'b1;
          state_nxt = ST_READ_REL;
        end
      end
      ST_READ_REL: begin
        if (!i_spi_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // idx is advanced when a word's done arrives, so o_init_idx already points at the
  // next word while INIT_REL waits and the word is ready to latch on re-entry.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state           <= ST_IDLE;
      cyc             <= '0;
      idx             <= '0;
      last_word       <= 1'b0;
      init_pend       <= 1'b0;
      init_done       <= 1'b0;
      overrun         <= 1'b0;
      o_adc_init_data <= '0;
    end else begin
      state     <= state_nxt;
      cyc       <= (state_nxt != state) ? '0 : cyc + 1'b1;
      init_pend <= (init_pend && !start_init) || i_init_req;
      overrun   <= (overrun && !i_init_req) || tick_drop;
      if (start_init) init_done <= 1'b0;
      else if (init_finish) init_done <= 1'b1;
      if (start_init || init_finish) idx <= '0;
      else if (xfer_done && idx != LAST_IDX) idx <= idx + 1'b1;
      if (xfer_done) last_word <= (idx == LAST_IDX);
      if (enter_xfer) o_adc_init_data <= i_init_word;
    end
  end

  assign o_state     = state;
  assign o_init_idx  = idx;
  assign o_init_done = init_done;
  assign o_overrun   = overrun;
  assign o_cnv       = (state == ST_CNV_HI);
  assign o_spi_start = (state == ST_INIT_XFER) || (state == ST_READ);
  assign o_adc_init  = (state == ST_INIT_XFER) || (state == ST_INIT_REL);

  logic signed [23:0] lane_sample;
  assign lane_sample = deinterleave(i_lane_data);

`ifdef AD4630_OFFSET_CAL_EN
  function automatic logic signed [23:0] sat24(input logic signed [24:0] x);
    if (x > 25'sd8388607) return 24'sh7FFFFF;
    else if (x < -25'sd8388608) return 24'sh800000;
    else return x[23:0];
  endfunction

  logic signed [23:0] raw_p0;
  logic               vld_p0;
  logic signed [24:0] diff_p0;
  assign diff_p0 = 25'(raw_p0) - 25'($signed(i_offset));

  // stage p0: capture de-interleaved sample
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      raw_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= capture;
      if (capture) raw_p0 <= lane_sample;
    end
  end

  // stage p1: offset removal with saturation
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
    end else begin
      o_sample_valid <= vld_p0;
      if (vld_p0) o_sample <= sat24(diff_p0);
    end
  end
`else
  logic unused_offset;
  assign unused_offset = ^i_offset;

  // stage p0: capture de-interleaved sample straight to the output
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
    end else begin
      o_sample_valid <= capture;
      if (capture) o_sample <= lane_sample;
    end
  end
`endif

endmodule

// File: tb/tb_ad4630_acq_ctrl.sv
// Directed bench for ad4630_acq_ctrl: init sequence, CNV pacing, lane reassembly,
// overrun, init/tick collision and async reset; offset cases when AD4630_OFFSET_CAL_EN is defined.
module tb_ad4630_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, init_req, spi_done;
  logic [2:0]  init_idx, state;
  logic [23:0] init_word, adc_init_data, lane_data, offset, sample;
  logic        spi_start, adc_init, cnv, sample_valid, init_done, overrun;

  always #5 clk = ~clk;

  ad4630_acq_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_init_req(init_req),
    .o_init_idx(init_idx), .i_init_word(init_word),
    .o_spi_start(spi_start), .i_spi_done(spi_done),
    .o_adc_init(adc_init), .o_adc_init_data(adc_init_data),
    .i_lane_data(lane_data), .i_offset(offset),
    .o_cnv(cnv), .o_sample(sample), .o_sample_valid(sample_valid),
    .o_init_done(init_done), .o_overrun(overrun), .o_state(state)
  );

  logic [23:0] words [8] = '{24'h140001, 24'h200A00, 24'h000000, 24'h3FFFFF, 24'h0, 24'h0, 24'h0, 24'h0};
  always_comb init_word = words[init_idx];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Engine model: answer done_dly cycles after start, drop done once start falls.
  int done_dly = 40;
  initial begin
    spi_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (spi_start && !spi_done) begin
        repeat (done_dly - 1) @(posedge clk);
        #1 spi_done = 1'b1;
        while (spi_start) begin @(posedge clk); #1; end
        spi_done = 1'b0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_start = 0, n_read_start = 0, n_cnv = 0, n_valid = 0, n_valid_long = 0, n_data_chg = 0;
  int cnv_rise_cyc = 0, cnv_width = 0, cnv_period = 0, start_lag = 0, done_rise_cyc = 0, lat = 0;
  logic p_start = 0, p_cnv = 0, p_valid = 0, p_done = 0, p_init = 0;
  logic [23:0] p_data = '0;
  logic [24:0] init_log[$];

  always @(negedge clk) begin
    if (spi_start && !p_start) begin
      n_start++;
      if (adc_init) init_log.push_back({1'b1, adc_init_data});
      else begin
        n_read_start++;
        start_lag = cyc - cnv_rise_cyc;
      end
    end else if (adc_init && p_init && adc_init_data != p_data) n_data_chg++;
    if (cnv && !p_cnv) begin
      if (n_cnv > 0) cnv_period = cyc - cnv_rise_cyc;
      n_cnv++;
      cnv_rise_cyc = cyc;
    end
    if (!cnv && p_cnv) cnv_width = cyc - cnv_rise_cyc;
    if (spi_done && !p_done && !adc_init) done_rise_cyc = cyc;
    if (sample_valid) begin
      n_valid++;
      lat = cyc - done_rise_cyc;
      if (p_valid) n_valid_long++;
    end
    p_start = spi_start; p_cnv = cnv; p_valid = sample_valid;
    p_done = spi_done; p_init = adc_init; p_data = adc_init_data;
  end

  task automatic wait_valid(input int budget, output bit ok);
    int v0;
    v0 = n_valid; ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (n_valid != v0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cnv(input int budget, output bit ok);
    int c0;
    c0 = n_cnv; ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (n_cnv != c0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_init_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (init_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_init_req();
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  logic [23:0] pat_in  [5] = '{24'h000FC0, 24'h03F000, 24'hFC0000, 24'h000020, 24'h040000};
  logic [23:0] pat_exp [5] = '{24'h444444, 24'h222222, 24'h111111, 24'h800000, 24'h000001};

`ifdef AD4630_OFFSET_CAL_EN
  function automatic logic [23:0] interleave(input logic [23:0] s);
    logic [23:0] l;
    l = '0;
    for (int j = 0; j < 6; j++)
      for (int k = 0; k < 4; k++) l[6*k+5-j] = s[23-4*j-k];
    return l;
  endfunction
  logic [23:0] off_raw [3] = '{24'h7FFFF0, 24'h800010, 24'h000100};
  logic [23:0] off_val [3] = '{24'hFFFF00, 24'h000100, 24'h000010};
  logic [23:0] off_exp [3] = '{24'h7FFFFF, 24'h800000, 24'h0000F0};
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0, s0, v0, p;
    rst = 1'b0; en = 1'b0; init_req = 1'b0; lane_data = '0; offset = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {cnv, spi_start, adc_init, init_done, sample_valid, overrun, state}, 0);
    chk("reset_sample", sample, 0);
    chk("reset_init_data", adc_init_data, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Four-word init sequence
    repeat (2) @(posedge clk); #1;
    pulse_init_req();
    wait_init_done(1000, ok);
    chk("init_done_rise", ok, 1);
    chk("init_after_done_low", {spi_done, 8'(n_start)}, {1'b0, 8'd4});
    chk("init_xfer_count", init_log.size(), 4);
    for (int i = 0; i < 4 && i < init_log.size(); i++)
      chk($sformatf("init_word%0d", i), init_log[i], {1'b1, words[i]});
    chk("init_data_stable", n_data_chg, 0);

    // Periodic acquisition and lane reassembly
    done_dly = 20;
    lane_data = 24'h00003F;
    en = 1'b1;
    wait_valid(700, ok);
    chk("first_valid", ok, 1);
    chk("sample_l0", sample, 24'h888888);
    chk("cnv_width", cnv_width, 4);
    chk("start_lag", start_lag, 34);
    chk("valid_latency", lat, EXP_LAT);
    for (int i = 0; i < 5; i++) begin
      lane_data = pat_in[i];
      wait_valid(600, ok);
      chk($sformatf("pat%0d_valid", i), ok, 1);
      chk($sformatf("pat%0d_sample", i), sample, pat_exp[i]);
    end
    chk("cnv_period", cnv_period, 500);
    chk("one_valid_per_cnv", n_valid, n_cnv);
    chk("valid_one_cycle", n_valid_long, 0);
    repeat (100) @(posedge clk); #1;
    chk("sample_hold", sample, 24'h000001);

`ifdef AD4630_OFFSET_CAL_EN
    for (int i = 0; i < 3; i++) begin
      lane_data = interleave(off_raw[i]);
      offset = off_val[i];
      wait_valid(600, ok);
      chk($sformatf("offset%0d", i), sample, off_exp[i]);
    end
    offset = '0;
    lane_data = 24'h040000;
    wait_valid(600, ok);
`endif

    // Enable drops mid-acquisition
    wait_cnv(600, ok);
    chk("cnv_before_disable", ok, 1);
    en = 1'b0;
    wait_valid(100, ok);
    chk("read_completes", ok, 1);
    chk("read_completes_data", sample, 24'h000001);
    c0 = n_cnv;
    repeat (600) @(posedge clk); #1;
    chk("no_cnv_disabled", n_cnv, c0);
    chk("overrun_clear", overrun, 0);

    // Stretched read overruns the period
    done_dly = 520;
    en = 1'b1;
    wait_cnv(600, ok);
    s0 = n_read_start; v0 = n_valid;
    wait_valid(700, ok);
    chk("long_read_valid", ok, 1);
    chk("overrun_set", overrun, 1);
    chk("no_double_start", n_read_start - s0, 1);
    chk("one_sample_long", n_valid - v0, 1);
    done_dly = 20;

    // Re-init clears overrun
    pulse_init_req();
    wait_init_done(1000, ok);
    chk("reinit_done", ok, 1);
    chk("reinit_overrun_clr", overrun, 0);
    chk("reinit_xfers", init_log.size(), 8);

    // Init request collides with a tick
    wait_cnv(700, ok);
    chk("cnv_before_collide", ok, 1);
    p = cnv_rise_cyc;
    while (cyc < p + 499) begin @(posedge clk); #1; end
    c0 = n_cnv;
    pulse_init_req();
    chk("collide_overrun", overrun, 1);
    @(posedge clk); #1;
    chk("collide_init_first", state, 3'd1);
    wait_init_done(1000, ok);
    chk("collide_init_done", ok, 1);
    chk("collide_no_cnv", n_cnv, c0);

    // Asynchronous reset during a read
    wait_cnv(700, ok);
    for (int k = 0; k < 60 && !spi_start; k++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk); #1;
    chk("mid_read_state", state, 3'd5);
    rst = 1'b0;
    #2;
    chk("reset_mid_read", {spi_start, cnv, init_done, adc_init, state}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
